pwm_rgb_encoder: RTL

//  - Turns per-colour 8-bit duty values (R/G/B, 0..255) from the colour sequencer into three PWM pin drives for the RGB LED.
//  - Sits between the colour-sequencing FSM and the LED pins.
//  - New duties are taken over a valid/ready handshake and applied only at a PWM period boundary, so a colour change never glitches mid-period.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 64 ++++++
 rtl/pwm_rgb_encoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the RGB PWM encoder.
// The fade stepper is built only when PWM_FADE_EN is defined.
package pwm_pkg;

    localparam int          DUTY_W  = 8;
    localparam logic [7:0]  PWM_TOP = 8'd254;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } hs_state_t;

    typedef struct packed {
        logic [DUTY_W-1:0] r;
        logic [DUTY_W-1:0] g;
        logic [DUTY_W-1:0] b;
    } rgb_duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: active duty register and registered pin compare.
// With PWM_FADE_EN the active duty walks toward target by FADE_STEP per load.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int FADE_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        pwm_cnt,
    input  logic              load,
    input  logic [DUTY_W-1:0] target,
    output logic              pwm,
    output logic              settle
);

    logic [DUTY_W-1:0] active;
    logic [DUTY_W-1:0] active_next;

`ifdef PWM_FADE_EN
    localparam logic signed [8:0] STEP = 9'(FADE_STEP);
    localparam logic [7:0]        STEP_U = 8'(FADE_STEP);

    logic signed [8:0] diff;

    // 9-bit signed distance so neither direction wraps at the 8-bit limits
    assign diff = $signed({1'b0, target}) - $signed({1'b0, active});

    always_comb begin
        active_next = target;
        settle      = 1'b1;
        if (diff > STEP) begin
            active_next = active + STEP_U;
            settle      = 1'b0;
        end else if (diff < -STEP) begin
            active_next = active - STEP_U;
            settle      = 1'b0;
        end
    end
`else
    always_comb begin
        active_next = target;
        settle      = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
        end else if (load) begin
            active <= active_next;
        end
    end

    // pwm_cnt tops out at 254, so duty 255 stays high for the whole period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (pwm_cnt < active);
        end
    end

endmodule

// File: rtl/pwm_rgb_encoder.sv
// RGB PWM encoder: prescaler, 255-step period counter, duty handshake FSM.
// Define PWM_FADE_EN to fade duties toward new targets instead of jumping.
module pwm_rgb_encoder
    import pwm_pkg::*;
#(
    parameter int PRESCALE  = 245,
    parameter int FADE_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       duty_valid,
    output logic       duty_ready,
    input  logic [7:0] duty_r,
    input  logic [7:0] duty_g,
    input  logic [7:0] duty_b,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       period_start
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        boundary;

    hs_state_t   state_q;
    hs_state_t   state_d;
    rgb_duty_t   pending;
    logic        load;
    logic        settle_r;
    logic        settle_g;
    logic        settle_b;

    assign tick     = (pre_cnt == PRE_LAST);
    assign boundary = tick && (pwm_cnt == PWM_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= (pwm_cnt == PWM_TOP) ? 8'd0 : pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A transfer in IDLE always goes through pending, even in a boundary cycle
    always_comb begin
        state_d    = state_q;
        duty_ready = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                duty_ready = 1'b1;
                if (duty_valid) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    load = 1'b1;
                    if (settle_r && settle_g && settle_b) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (duty_valid && duty_ready) begin
            pending <= '{r: duty_r, g: duty_g, b: duty_b};
        end
    end

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_chan_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .load    (load),
        .target  (pending.r),
        .pwm     (pwm_r),
        .settle  (settle_r)
    );

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_chan_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .load    (load),
        .target  (pending.g),
        .pwm     (pwm_g),
        .settle  (settle_g)
    );

    pwm_channel #(.FADE_STEP(FADE_STEP)) u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .load    (load),
        .target  (pending.b),
        .pwm     (pwm_b),
        .settle  (settle_b)
    );

endmodule
